// File: rtl/uart_pkg.sv
// ==========================================================================
// uart_pkg : shared UART types and parity helpers                 rev 1.0
// ==========================================================================
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } uart_par_t;

   localparam int unsigned MAX_DATA_BITS = 9;

   function automatic logic par_enabled(input uart_par_t m);
      return (m == PAR_EVEN) || (m == PAR_ODD);
   endfunction

   // Zero-extension to MAX_DATA_BITS leaves the XOR reduction unchanged.
   function automatic logic par_bit(input logic [MAX_DATA_BITS-1:0] d, input uart_par_t m);
      return (m == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ==========================================================================
// uart_baud_tick : bit-period timer with clear, shared by TX and RX  rev 1.0
// ==========================================================================
`default_nettype none

module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 2604
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic bit_tick_o,
   output logic pre_tick_o
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_tick_o = (cnt_q == LAST);
   // One cycle ahead of bit_tick, lets callers register end-of-bit flags.
   assign pre_tick_o = (cnt_q == PRE);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr_i || bit_tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// ==========================================================================
// uart_tx_frame : UART transmitter with one-entry holding buffer   rev 1.0
// ==========================================================================
`default_nettype none

module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 2604
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [1:0]           par_mode,
   input  logic                 stop2,
   output logic                 TX,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int unsigned BCW = $clog2(DATA_BITS + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   logic                 buf_full_q;
   logic [DATA_BITS-1:0] buf_data_q;
   uart_par_t            buf_par_q;
   logic                 buf_stop2_q;

   uart_tx_state_t       state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [BCW-1:0]       bit_cnt_q;
   logic                 stop_cnt_q;
   logic                 par_bit_q;
   logic                 par_en_q;
   logic                 stop2_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 done_q;

   logic bit_tick;
   logic pre_tick;
   logic accept;
   logic last_stop;
   logic unload;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (state_q == IDLE),
      .bit_tick_o (bit_tick),
      .pre_tick_o (pre_tick)
   );

   assign tx_ready  = ~buf_full_q;
   assign accept    = tx_valid & ~buf_full_q;
   assign last_stop = (state_q == STOP) && (!stop2_q || stop_cnt_q);
   // Buffer drains into the shifter from IDLE or straight at the end of a frame.
   assign unload    = buf_full_q && ((state_q == IDLE) || (last_stop && bit_tick));

   assign TX      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_full_q  <= 1'b0;
         buf_data_q  <= '0;
         buf_par_q   <= PAR_NONE;
         buf_stop2_q <= 1'b0;
      end else if (accept) begin
         buf_full_q  <= 1'b1;
         buf_data_q  <= tx_data;
         buf_par_q   <= uart_par_t'(par_mode);
         buf_stop2_q <= stop2;
      end else if (unload) begin
         buf_full_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_bit_q  <= 1'b0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= last_stop && pre_tick;
         if (unload) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            shift_q    <= buf_data_q;
            par_bit_q  <= par_bit(MAX_DATA_BITS'(buf_data_q), buf_par_q);
            par_en_q   <= par_enabled(buf_par_q);
            stop2_q    <= buf_stop2_q;
            stop_cnt_q <= 1'b0;
         end else if (bit_tick) begin
            case (state_q)
               START: begin
                  state_q   <= DATA;
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= '0;
               end
               DATA: begin
                  if (bit_cnt_q == LAST_BIT) begin
                     if (par_en_q) begin
                        state_q <= PARITY;
                        tx_q    <= par_bit_q;
                     end else begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
               PARITY: begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
               end
               STOP: begin
                  if (last_stop) begin
                     state_q <= IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     stop_cnt_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ==========================================================================
// tb_uart_tx_frame : randomized + directed bench for uart_tx_frame  rev 1.0
// ==========================================================================
`default_nettype none

module tb_uart_tx_frame;

   localparam int CPB0 = 16;
   localparam int NB0  = 8;
   localparam int CPB1 = 4;
   localparam int NB1  = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   [2];
   logic       valid [2];
   logic [8:0] din   [2];
   logic [1:0] pm    [2];
   logic       s2    [2];
   logic       tx    [2];
   logic       rdy   [2];
   logic       busy  [2];
   logic       done  [2];

   int cpb   [2] = '{CPB0, CPB1};
   int nbits [2] = '{NB0, NB1};

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   uart_tx_frame #(.DATA_BITS(NB0), .CLKS_PER_BIT(CPB0)) dut0 (
      .clk(clk), .rst(rst[0]), .tx_data(din[0][NB0-1:0]), .tx_valid(valid[0]),
      .tx_ready(rdy[0]), .par_mode(pm[0]), .stop2(s2[0]), .TX(tx[0]),
      .tx_busy(busy[0]), .tx_done(done[0]));

   uart_tx_frame #(.DATA_BITS(NB1), .CLKS_PER_BIT(CPB1)) dut1 (
      .clk(clk), .rst(rst[1]), .tx_data(din[1][NB1-1:0]), .tx_valid(valid[1]),
      .tx_ready(rdy[1]), .par_mode(pm[1]), .stop2(s2[1]), .TX(tx[1]),
      .tx_busy(busy[1]), .tx_done(done[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the line is a list of frame bits, each lasting cpb cycles.
   bit        mfull   [2];
   bit [8:0]  mdata   [2];
   bit [1:0]  mpm     [2];
   bit        ms2     [2];
   bit [15:0] fb      [2];
   int        flen    [2];
   int        rem     [2];
   int        acc_cnt [2];

   task automatic build(input bit [8:0] d, input int nb, input bit [1:0] m, input bit st2,
                        output bit [15:0] b, output int n);
      int ones;
      b = '0;
      n = 1;
      ones = 0;
      for (int k = 0; k < nb; k++) begin
         b[n] = d[k];
         ones += int'(d[k]);
         n++;
      end
      if (m == 2'b01 || m == 2'b10) begin
         b[n] = (m == 2'b01) ? bit'(ones % 2) : bit'(1 - ones % 2);
         n++;
      end
      b[n] = 1'b1;
      n++;
      if (st2) begin
         b[n] = 1'b1;
         n++;
      end
   endtask

   always @(posedge clk) begin
      bit acc;
      int n;
      for (int i = 0; i < 2; i++) begin
         if (rst[i] === 1'b1) begin
            rem[i]   = 0;
            mfull[i] = 1'b0;
         end else begin
            acc = (valid[i] === 1'b1) && !mfull[i];
            if (rem[i] > 0) rem[i]--;
            if (rem[i] == 0 && mfull[i]) begin
               build(mdata[i], nbits[i], mpm[i], ms2[i], fb[i], n);
               flen[i]  = n * cpb[i];
               rem[i]   = flen[i];
               mfull[i] = 1'b0;
            end
            if (acc) begin
               mdata[i] = din[i] & 9'((1 << nbits[i]) - 1);
               mpm[i]   = pm[i];
               ms2[i]   = s2[i];
               mfull[i] = 1'b1;
               acc_cnt[i]++;
            end
         end
      end
   end

   function automatic bit exp_tx(input int i);
      if (rem[i] == 0) return 1'b1;
      return fb[i][(flen[i] - rem[i]) / cpb[i]];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("TX%0d", i),       32'(tx[i]),   32'(exp_tx(i)));
            chk($sformatf("tx_busy%0d", i),  32'(busy[i]), 32'(rem[i] > 0));
            chk($sformatf("tx_done%0d", i),  32'(done[i]), 32'(rem[i] == 1));
            chk($sformatf("tx_ready%0d", i), 32'(rdy[i]),  32'(!mfull[i]));
         end
      end
   end

   task automatic send(input int i, input bit [8:0] d, input bit [1:0] m, input bit st2);
      int c = acc_cnt[i];
      int t = 0;
      valid[i] = 1'b1;
      din[i]   = d;
      pm[i]    = m;
      s2[i]    = st2;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (acc_cnt[i] == c && t < 5000);
      if (t >= 5000) chk("accept timeout", 0, 1);
      valid[i] = 1'b0;
      din[i]   = 9'($urandom);
      pm[i]    = 2'($urandom);
      s2[i]    = 1'($urandom);
   endtask

   task automatic wait_idle(input int i);
      int t = 0;
      while ((rem[i] != 0 || mfull[i]) && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 5000) chk("idle timeout", 0, 1);
   endtask

   task automatic pulse_rst(input int i);
      rst[i] = 1'b1;
      @(posedge clk);
      #1;
      rst[i] = 1'b0;
   endtask

   // Cycle k counts from the first cycle after the accept edge.
   task automatic frame_lit(input int i, input bit [15:0] lit, input int nb, input int dcyc,
                            input string nm);
      int donek = 0;
      for (int k = 1; k <= dcyc + 2; k++) begin
         @(posedge clk);
         #1;
         if (((k - 1) % cpb[i]) == cpb[i] / 2 && ((k - 1) / cpb[i]) < nb)
            chk($sformatf("%s bit%0d", nm, (k - 1) / cpb[i]), 32'(tx[i]), 32'(lit[(k - 1) / cpb[i]]));
         if (done[i] === 1'b1 && donek == 0) donek = k;
      end
      chk({nm, " done cycle"}, donek, dcyc);
   endtask

   task automatic back_to_back();
      send(0, 9'h55, 2'b00, 1'b0);
      fork
         send(0, 9'hAA, 2'b00, 1'b0);
         begin
            int   d1 = 0;
            int   d2 = 0;
            int   bl = 0;
            logic r10 = 1'b1;
            logic t161 = 1'b1;
            for (int k = 1; k <= 325; k++) begin
               @(posedge clk);
               #1;
               if (done[0] === 1'b1) begin
                  if (d1 == 0) d1 = k;
                  else if (d2 == 0) d2 = k;
               end
               if (k <= 320 && busy[0] !== 1'b1) bl++;
               if (k == 10)  r10  = rdy[0];
               if (k == 161) t161 = tx[0];
            end
            chk("b2b first done", d1, 160);
            chk("b2b second done", d2, 320);
            chk("b2b busy drops", bl, 0);
            chk("b2b ready while full", 32'(r10), 0);
            chk("b2b second start", 32'(t161), 0);
         end
      join
   endtask

   task automatic reset_mid_frame();
      int bz = 0;
      send(0, 9'h3C, 2'b01, 1'b1);
      send(0, 9'hC3, 2'b00, 1'b0);
      repeat (68) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      chk("rst TX", 32'(tx[0]), 1);
      chk("rst ready", 32'(rdy[0]), 1);
      chk("rst busy", 32'(busy[0]), 0);
      chk("rst done", 32'(done[0]), 0);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (busy[0] !== 1'b0 || done[0] !== 1'b0) bz++;
      end
      chk("rst stays idle", bz, 0);
   endtask

   task automatic rand_run(input int i);
      repeat (25) begin
         repeat ($urandom_range(0, 3 * cpb[i])) @(posedge clk);
         #1;
         if ($urandom_range(0, 19) == 0) pulse_rst(i);
         send(i, 9'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      wait_idle(i);
   endtask

   initial begin
      bit [15:0] b;
      int        n;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; valid[i] = 1'b0; din[i] = '0; pm[i] = '0; s2[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset TX", 32'(tx[0]), 1);
      chk("reset ready", 32'(rdy[0]), 1);
      chk("reset busy", 32'(busy[0]), 0);
      chk("reset done", 32'(done[0]), 0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      build(9'hA5, 8, 2'b01, 1'b0, b, n);
      chk("model A5 even len", n, 11);
      chk("model A5 even par", 32'(b[9]), 0);
      build(9'h1F, 5, 2'b10, 1'b0, b, n);
      chk("model 1F odd frame", 32'(b[7:0]), 32'h00BE);

      repeat (3) @(posedge clk);
      #1;
      send(0, 9'hA5, 2'b00, 1'b0); frame_lit(0, 16'b1101001010,   10, 160, "8N1 A5");
      wait_idle(0);
      send(0, 9'hA5, 2'b01, 1'b0); frame_lit(0, 16'b10101001010,  11, 176, "A5 even");
      wait_idle(0);
      send(0, 9'hA5, 2'b10, 1'b0); frame_lit(0, 16'b11101001010,  11, 176, "A5 odd");
      wait_idle(0);
      send(0, 9'h07, 2'b01, 1'b0); frame_lit(0, 16'b11000001110,  11, 176, "07 even");
      wait_idle(0);
      send(0, 9'hA5, 2'b11, 1'b0); frame_lit(0, 16'b1101001010,   10, 160, "A5 rsvd");
      wait_idle(0);
      send(0, 9'h00, 2'b01, 1'b1); frame_lit(0, 16'b110000000000, 12, 192, "00 2stop");
      wait_idle(0);
      back_to_back();
      wait_idle(0);
      reset_mid_frame();
      send(0, 9'hA5, 2'b00, 1'b0); frame_lit(0, 16'b1101001010,   10, 160, "post-rst A5");
      wait_idle(0);
      send(1, 9'h1F, 2'b10, 1'b0); frame_lit(1, 16'b10111110,      8,  32, "5b 1F odd");
      wait_idle(1);

      fork
         rand_run(0);
         rand_run(1);
      join
      repeat (4) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
